// File: rtl/perf_counter_sampler_pkg.sv
// rtl/perf_counter_sampler_pkg.sv - shared types and constants for the perf-counter sampler
package perf_counter_sampler_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned PERF_SEQ_WIDTH = 16;

  // Low 5 bits of the first (ML1_ICACHE_MISS) and last (MIF_EMPTY) counter CSRs
  localparam logic [4:0] PERF_FIRST_ADDR = 5'd3;
  localparam logic [4:0] PERF_LAST_ADDR  = 5'd16;

  typedef struct packed {
    logic [4:0]                addr;
    logic [XLEN-1:0]           data;
    logic [PERF_SEQ_WIDTH-1:0] seq;
    logic                      last;
  } perf_sample_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_SEND   = 2'd2
  } smp_state_e;

endpackage

// File: rtl/perf_counter_sampler_timer.sv
// rtl/perf_counter_sampler_timer.sv - reloadable down-counter producing periodic sweep ticks
module perf_sample_timer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic [31:0] interval_i,
  output logic        tick_o
);

  logic [31:0] r_cnt;

  // A zero interval disables ticking even if the counter still holds 1
  assign tick_o = (interval_i != 32'd0) && (r_cnt == 32'd1);

  // Count down; reload on the tick and whenever the timer is switched back on from 0
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= 32'd0;
    end else if (clr_i) begin
      r_cnt <= interval_i;
    end else if (interval_i == 32'd0) begin
      r_cnt <= 32'd0;
    end else if (r_cnt <= 32'd1) begin
      r_cnt <= interval_i;
    end else begin
      r_cnt <= r_cnt - 32'd1;
    end
  end

endmodule

// File: rtl/perf_counter_sampler.sv
// rtl/perf_counter_sampler.sv - sweeps perf counters over the shared port and streams samples
module perf_counter_sampler
  import perf_counter_sampler_pkg::*;
#(
  parameter logic [4:0]  FirstAddr = PERF_FIRST_ADDR,
  parameter logic [4:0]  LastAddr  = PERF_LAST_ADDR,
  parameter int unsigned SeqWidth  = PERF_SEQ_WIDTH
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            debug_mode_i,
  input  logic [31:0]     interval_i,
  input  logic            start_i,
  input  logic            clear_on_rd_i,
  input  logic            csr_req_i,
  input  logic [4:0]      csr_addr_i,
  input  logic            csr_we_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic [4:0]      pc_addr_o,
  output logic            pc_we_o,
  output logic [XLEN-1:0] pc_wdata_o,
  input  logic [XLEN-1:0] pc_rdata_i,
  output logic            smp_valid_o,
  input  logic            smp_ready_i,
  output perf_sample_t    smp_o,
  output logic            busy_o,
  output logic            overrun_o
);

  localparam logic [SeqWidth-1:0] SeqOne = SeqWidth'(1);

  smp_state_e          r_state;
  smp_state_e          w_next;
  logic [4:0]          r_cur_addr;
  logic                r_clear_q;
  logic [SeqWidth-1:0] r_seq;
  perf_sample_t        r_smp;
  logic                w_tick;
  logic                w_trigger;
  logic                w_start;
  logic                w_access;
  logic                w_handshake;
  logic                w_overrun;

  perf_sample_timer u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (clr_i),
    .interval_i (interval_i),
    .tick_o     (w_tick)
  );

  assign w_trigger   = w_tick | start_i;
  assign csr_rdata_o = pc_rdata_i;
  assign smp_valid_o = (r_state == ST_SEND);
  assign smp_o       = r_smp;
  assign busy_o      = (r_state != ST_IDLE);
  assign overrun_o   = w_overrun & ~clr_i;

  // Next-state logic: triggers start a sweep only from IDLE outside debug mode
  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_access    = 1'b0;
    w_handshake = 1'b0;
    w_overrun   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_trigger && !debug_mode_i) begin
          w_start = 1'b1;
          w_next  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_overrun = w_trigger;
        if (!csr_req_i) begin
          w_access = 1'b1;
          w_next   = ST_SEND;
        end
      end
      ST_SEND: begin
        w_overrun = w_trigger;
        if (smp_ready_i) begin
          w_handshake = 1'b1;
          w_next      = r_smp.last ? ST_IDLE : ST_ACCESS;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Port mux: the CSR file always wins; the sampler drives only in ACCESS
  always_comb begin
    pc_addr_o  = 5'd0;
    pc_we_o    = 1'b0;
    pc_wdata_o = '0;
    if (csr_req_i) begin
      pc_addr_o  = csr_addr_i;
      pc_we_o    = csr_we_i;
      pc_wdata_o = csr_wdata_i;
    end else if (r_state == ST_ACCESS) begin
      pc_addr_o = r_cur_addr;
      pc_we_o   = r_clear_q;
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else if (clr_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Sweep datapath: address walk, clear mode, sample capture and sequence number
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cur_addr <= FirstAddr;
      r_clear_q  <= 1'b0;
      r_seq      <= '0;
      r_smp      <= '0;
    end else if (clr_i) begin
      r_cur_addr <= FirstAddr;
      r_clear_q  <= 1'b0;
      r_seq      <= '0;
      r_smp      <= '0;
    end else begin
      if (w_start) begin
        r_cur_addr <= FirstAddr;
        r_clear_q  <= clear_on_rd_i;
      end
      if (w_access) begin
        r_smp.addr <= r_cur_addr;
        r_smp.data <= pc_rdata_i;
        r_smp.seq  <= r_seq;
        r_smp.last <= (r_cur_addr == LastAddr);
      end
      if (w_handshake) begin
        if (r_smp.last) begin
          r_seq <= r_seq + SeqOne;
        end else begin
          r_cur_addr <= r_cur_addr + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_perf_counter_sampler.sv
// tb/tb_perf_counter_sampler.sv - self-checking bench for perf_counter_sampler
module tb_perf_counter_sampler;
  import perf_counter_sampler_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_ni, clr_i, debug_mode_i, start_i, clear_on_rd_i;
  logic         csr_req_i, csr_we_i, smp_ready_i;
  logic [31:0]  interval_i, csr_wdata_i, csr_rdata_o, pc_wdata_o, pc_rdata_i;
  logic [4:0]   csr_addr_i, pc_addr_o;
  logic         pc_we_o, smp_valid_o, busy_o, overrun_o;
  perf_sample_t smp_o;

  perf_counter_sampler dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .debug_mode_i(debug_mode_i),
    .interval_i(interval_i), .start_i(start_i), .clear_on_rd_i(clear_on_rd_i),
    .csr_req_i(csr_req_i), .csr_addr_i(csr_addr_i), .csr_we_i(csr_we_i),
    .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o), .pc_addr_o(pc_addr_o),
    .pc_we_o(pc_we_o), .pc_wdata_o(pc_wdata_o), .pc_rdata_i(pc_rdata_i),
    .smp_valid_o(smp_valid_o), .smp_ready_i(smp_ready_i), .smp_o(smp_o),
    .busy_o(busy_o), .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  // Counter block model: same-cycle read, write-after-read, write beats an increment
  logic [31:0] cnt [32];
  logic        preload, inc3;
  always @(posedge clk_i) begin
    if (preload) begin
      for (int a = 0; a < 32; a++) cnt[a] <= 32'(100 + a);
    end else begin
      if (pc_we_o) cnt[pc_addr_o] <= pc_wdata_o;
      if (inc3 && !(pc_we_o && pc_addr_o == 5'd3)) cnt[3] <= cnt[3] + 32'd1;
    end
  end
  assign pc_rdata_i = cnt[pc_addr_o];

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        last;
  } vec_t;
  vec_t vec [14];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!smp_valid_o && k < 60) begin
      step();
      k++;
    end
    chk("entry_valid", 64'(smp_valid_o), 64'(1));
  endtask

  task automatic check_entry(input int i, input logic [15:0] s);
    wait_valid();
    chk($sformatf("entry_addr_%0d", i), 64'(smp_o.addr), 64'(vec[i].addr));
    chk($sformatf("entry_data_%0d", i), 64'(smp_o.data), 64'(vec[i].data));
    chk($sformatf("entry_last_%0d", i), 64'(smp_o.last), 64'(vec[i].last));
    chk($sformatf("entry_seq_%0d", i),  64'(smp_o.seq),  64'(s));
    step();
  endtask

  task automatic sweep(input logic [15:0] s, input int first);
    for (int i = first; i < 14; i++) check_entry(i, s);
  endtask

  task automatic csr_read(input logic [4:0] a, input logic [31:0] exp, input string name);
    csr_req_i  = 1'b1;
    csr_addr_i = a;
    #1;
    chk(name, 64'(csr_rdata_o), 64'(exp));
    csr_req_i  = 1'b0;
    csr_addr_i = 5'd0;
    #1;
  endtask

  int          rise [3];
  logic [15:0] seqs [3];
  int          nr, nl, oc, k;
  logic        prev_busy;
  perf_sample_t e;

  initial begin
    for (int i = 0; i < 14; i++) vec[i] = '{5'(3 + i), 32'(103 + i), (i == 13)};

    rst_ni = 1'b0; clr_i = 1'b0; debug_mode_i = 1'b0; interval_i = 32'd0;
    start_i = 1'b0; clear_on_rd_i = 1'b0; csr_req_i = 1'b0; csr_addr_i = 5'd0;
    csr_we_i = 1'b0; csr_wdata_i = 32'd0; smp_ready_i = 1'b1; preload = 1'b1; inc3 = 1'b0;
    step(2);
    preload = 1'b0;
    chk("rst_valid",   64'(smp_valid_o), 64'(0));
    chk("rst_busy",    64'(busy_o),      64'(0));
    chk("rst_overrun", 64'(overrun_o),   64'(0));
    chk("rst_smp",     64'(smp_o),       64'(0));
    chk("rst_pc_we",   64'(pc_we_o),     64'(0));
    rst_ni = 1'b1;
    step();

    // 1: plain sweep, latency T+1 access, T+2 valid
    pulse_start();
    chk("lat_busy",    64'(busy_o),    64'(1));
    chk("lat_pc_addr", 64'(pc_addr_o), 64'(3));
    chk("lat_pc_we",   64'(pc_we_o),   64'(0));
    step();
    chk("lat_valid",   64'(smp_valid_o), 64'(1));
    sweep(16'd0, 0);
    chk("t1_idle", 64'(busy_o), 64'(0));
    csr_read(5'd7,  32'd107, "t1_cnt7");
    csr_read(5'd16, 32'd116, "t1_cnt16");

    // 2: read-and-clear, increment lost in the access cycle, counted the next
    clear_on_rd_i = 1'b1;
    pulse_start();
    clear_on_rd_i = 1'b0;
    chk("t2_clear_we", 64'(pc_we_o), 64'(1));
    inc3 = 1'b1;
    step();
    chk("t2_e3_addr", 64'(smp_o.addr), 64'(3));
    chk("t2_e3_data", 64'(smp_o.data), 64'(103));
    step();
    inc3 = 1'b0;
    sweep(16'd1, 1);
    csr_read(5'd3,  32'd1, "t2_cnt3");
    csr_read(5'd4,  32'd0, "t2_cnt4");
    csr_read(5'd16, 32'd0, "t2_cnt16");
    preload = 1'b1;
    step();
    preload = 1'b0;

    // 3: CSR file holds the port for 5 cycles while the sampler waits at addr 7
    pulse_start();
    for (int i = 0; i < 4; i++) check_entry(i, 16'd2);
    chk("t3_acc_addr", 64'(pc_addr_o), 64'(7));
    csr_req_i  = 1'b1;
    csr_addr_i = 5'd7;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_csr_rdata", 64'(csr_rdata_o), 64'(107));
      chk("t3_stall_valid", 64'(smp_valid_o), 64'(0));
      chk("t3_stall_we", 64'(pc_we_o), 64'(0));
      step();
    end
    csr_req_i  = 1'b0;
    csr_addr_i = 5'd0;
    sweep(16'd2, 4);

    // 4: periodic sweeps every 40 cycles, then overruns while stuck
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    interval_i = 32'd40;
    nr = 0; nl = 0; prev_busy = 1'b0;
    for (int cyc = 0; cyc < 300 && nl < 3; cyc++) begin
      if (busy_o && !prev_busy && nr < 3) begin
        rise[nr] = cyc;
        nr++;
      end
      if (smp_valid_o && smp_ready_i && smp_o.last) begin
        seqs[nl] = smp_o.seq;
        nl++;
      end
      prev_busy = busy_o;
      if (nl < 3) step();
    end
    chk("t4_sweeps", 64'(nl), 64'(3));
    chk("t4_rises", 64'(nr), 64'(3));
    chk("t4_period01", 64'(rise[1] - rise[0]), 64'(40));
    chk("t4_period12", 64'(rise[2] - rise[1]), 64'(40));
    chk("t4_seq0", 64'(seqs[0]), 64'(0));
    chk("t4_seq1", 64'(seqs[1]), 64'(1));
    chk("t4_seq2", 64'(seqs[2]), 64'(2));
    step();
    smp_ready_i = 1'b0;
    interval_i  = 32'd20;
    wait_valid();
    oc = 0;
    for (int i = 0; i < 100; i++) begin
      if (overrun_o) oc++;
      step();
    end
    chk("t4_overruns", 64'(oc >= 3), 64'(1));
    chk("t4_stuck_seq", 64'(smp_o.seq), 64'(3));
    chk("t4_stuck_addr", 64'(smp_o.addr), 64'(3));
    interval_i  = 32'd0;
    smp_ready_i = 1'b1;
    sweep(16'd3, 0);

    // 5: sink back-pressure on entry 5 holds the sample and blocks port accesses
    pulse_start();
    check_entry(0, 16'd4);
    check_entry(1, 16'd4);
    k = 0;
    while (!smp_valid_o && k < 10) begin
      step();
      k++;
    end
    smp_ready_i = 1'b0;
    e.addr = 5'd5; e.data = 32'd105; e.seq = 16'd4; e.last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t5_hold_smp", 64'(smp_o), 64'(e));
      chk("t5_hold_port", 64'({pc_we_o, pc_addr_o}), 64'(0));
      step();
    end
    smp_ready_i = 1'b1;
    sweep(16'd4, 2);

    // 6: async reset and sync clear mid-sweep, debug mode gating
    pulse_start();
    step(3);
    #2 rst_ni = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(smp_valid_o), 64'(0));
    chk("t6_rst_busy",  64'(busy_o),      64'(0));
    chk("t6_rst_smp",   64'(smp_o),       64'(0));
    step();
    rst_ni = 1'b1;
    step();
    pulse_start();
    step(2);
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    chk("t6_clr_valid", 64'(smp_valid_o), 64'(0));
    chk("t6_clr_busy",  64'(busy_o),      64'(0));
    chk("t6_clr_smp",   64'(smp_o),       64'(0));
    debug_mode_i = 1'b1;
    pulse_start();
    chk("t6_dbg_busy",    64'(busy_o),    64'(0));
    chk("t6_dbg_overrun", 64'(overrun_o), 64'(0));
    step(3);
    chk("t6_dbg_busy_later", 64'(busy_o), 64'(0));
    debug_mode_i = 1'b0;
    pulse_start();
    check_entry(0, 16'd0);
    debug_mode_i = 1'b1;
    sweep(16'd0, 1);
    debug_mode_i = 1'b0;
    chk("t6_dbg_sweep_done", 64'(busy_o), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
